// File: rtl/fp_pkg.sv
// Shared encodings and field helpers for the sequential FP ALU and its divider.
package fp_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    DIV  = 3'd2,
    NORM = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_DZ  = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Prepends the implied leading one above a man_w-bit fraction.
  function automatic logic [63:0] fp_hidden(input logic [62:0] frac, input int man_w);
    return (64'd1 << man_w) | {1'b0, frac};
  endfunction

endpackage

// File: rtl/fp_div_iter.sv
// Restoring divider: the first quotient bit is produced on the start edge, one more per cycle after.
// done is high in the cycle computing the final bit; quo is valid from the next cycle until the next start.
module fp_div_iter #(
  parameter int MAN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAN_W:0]   dividend,
  input  logic [MAN_W:0]   divisor,
  output logic             busy,
  output logic             done,
  output logic [MAN_W+1:0] quo
);
  localparam int QW = MAN_W + 2;
  localparam int CW = $clog2(QW);

  logic [QW-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] src, diff;
  logic          ge;

  always_comb begin
    src   = start ? {1'b0, dividend} : rem_q;
    ge    = (src >= {1'b0, divisor});
    diff  = ge ? (src - {1'b0, divisor}) : src;
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    if (start) begin
      rem_d = diff << 1;
      quo_d = {{(QW-1){1'b0}}, ge};
      cnt_d = CW'(QW - 1);
    end else if (cnt_q != '0) begin
      rem_d = diff << 1;
      quo_d = {quo_q[QW-2:0], ge};
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CW'(1));
  assign quo  = quo_q;

endmodule

// File: rtl/fp_alu_seq.sv
// Multi-cycle add/sub/mul/div on packed {sign, exp, frac} operands, truncating, with {ovf, unf, dz} flags.
// Define FPU_DIV_EN to build the iterative divider; without it op=11 returns result 0 with all flags set.
module fp_alu_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);
  localparam int BIAS = fp_bias(EXP_W);
  localparam int MW   = 2 * MAN_W + 2;  // working mantissa, value = mant * 2^-(2*MAN_W)
  localparam int XW   = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic                 sign_q, sign_d;
  logic signed [XW-1:0] exp_q, exp_d;
  logic [MW-1:0]        mant_q, mant_d;
  logic                 spc_q, spc_d;
  logic [W-1:0]         spc_res_q, spc_res_d;
  logic [2:0]           spc_flg_q, spc_flg_d;
  logic [W-1:0]         result_q, result_d;
  logic [2:0]           flags_q, flags_d;

  logic accept, exec_direct, exec_div, div_leave;

  logic             sa, sb, sb_eff, a_big, s_big, s_sml, inf_sign;
  logic [EXP_W-1:0] ea, eb, e_big, e_sml, sh;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   ma, mb, m_big, m_sml;
  logic [MW-1:0]    m_big_w, m_sml_w;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;
  assign sb_eff  = sb ^ (op_q == OP_SUB);
  assign ma      = (MAN_W+1)'(fp_hidden(63'(fa), MAN_W));
  assign mb      = (MAN_W+1)'(fp_hidden(63'(fb), MAN_W));
  assign a_big   = ({ea, fa} >= {eb, fb});
  assign e_big   = a_big ? ea : eb;
  assign e_sml   = a_big ? eb : ea;
  assign m_big   = a_big ? ma : mb;
  assign m_sml   = a_big ? mb : ma;
  assign s_big   = a_big ? sa : sb_eff;
  assign s_sml   = a_big ? sb_eff : sa;
  assign sh      = e_big - e_sml;
  assign m_big_w = MW'(m_big) << MAN_W;
  assign m_sml_w = (int'(sh) >= MAN_W + 2) ? '0 : ((MW'(m_sml) << MAN_W) >> sh);
  assign inf_sign = (op_q == OP_MUL || op_q == OP_DIV) ? (sa ^ sb) :
                    ((ea == EXP_ONES) ? sa : sb_eff);

`ifdef FPU_DIV_EN
  logic             div_busy, div_done;
  logic [MAN_W+1:0] div_quo;

  fp_div_iter #(.MAN_W(MAN_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    ((state_q == EXEC) && exec_div),
    .dividend (ma),
    .divisor  (mb),
    .busy     (div_busy),
    .done     (div_done),
    .quo      (div_quo)
  );

  assign div_leave = div_done || !div_busy;
`else
  assign div_leave = 1'b1;
`endif

  logic [MW-1:0]    mant_n, norm_sh;
  logic [MAN_W-1:0] frac_n;
  int               lead, exp_n;

  always_comb begin
    mant_n = mant_q;
`ifdef FPU_DIV_EN
    // Quotient has its integer bit at MAN_W+1; rescale onto the product binary point.
    if (op_q == OP_DIV) mant_n = MW'(div_quo) << (MAN_W - 1);
`endif
    lead = 0;
    for (int i = 0; i < MW; i++) begin
      if (mant_n[i]) lead = i;
    end
    exp_n   = int'(exp_q) + lead - 2 * MAN_W;
    norm_sh = mant_n << (MW - 1 - lead);
    frac_n  = MAN_W'(norm_sh >> (MAN_W + 1));
  end

  always_comb begin
    a_d = a_q;  b_d = b_q;  op_d = op_q;
    sign_d = sign_q;  exp_d = exp_q;  mant_d = mant_q;
    spc_d = spc_q;  spc_res_d = spc_res_q;  spc_flg_d = spc_flg_q;
    result_d = result_q;  flags_d = flags_q;
    exec_direct = 1'b0;
    exec_div    = 1'b0;

    if (accept) begin
      a_d  = a;
      b_d  = b;
      op_d = op_e'(op);
    end

    if (state_q == EXEC) begin
      unique case (op_q)
        OP_MUL: begin
          sign_d = sa ^ sb;
          exp_d  = XW'(ea) + XW'(eb) - XW'(BIAS);
          mant_d = MW'(ma) * MW'(mb);
        end
        OP_DIV: begin
          sign_d = sa ^ sb;
          exp_d  = XW'(ea) - XW'(eb) + XW'(BIAS);
          mant_d = '0;
        end
        default: begin
          sign_d = s_big;
          exp_d  = XW'(e_big);
          mant_d = (s_big == s_sml) ? (m_big_w + m_sml_w) : (m_big_w - m_sml_w);
        end
      endcase

      // Results decided by operand class bypass the normaliser.
      spc_d     = 1'b0;
      spc_res_d = '0;
      spc_flg_d = '0;
      if (ea == EXP_ONES || eb == EXP_ONES) begin
        spc_d              = 1'b1;
        spc_res_d          = {inf_sign, EXP_ONES, {MAN_W{1'b0}}};
        spc_flg_d[FLG_OVF] = 1'b1;
      end else if (op_q == OP_MUL || op_q == OP_DIV) begin
        if (ea == '0 || (op_q == OP_MUL && eb == '0)) begin
          spc_d     = 1'b1;
          spc_res_d = {sa ^ sb, {(W-1){1'b0}}};
        end
      end else if (ea == '0 && eb == '0) begin
        spc_d     = 1'b1;
        spc_res_d = {sa & sb_eff, {(W-1){1'b0}}};
      end else if (ea == '0) begin
        spc_d     = 1'b1;
        spc_res_d = {sb_eff, eb, fb};
      end else if (eb == '0) begin
        spc_d     = 1'b1;
        spc_res_d = a_q;
      end

      if (op_q == OP_DIV) begin
`ifdef FPU_DIV_EN
        if (eb == '0) begin
          exec_direct       = 1'b1;
          result_d          = {sa ^ sb, EXP_ONES, {MAN_W{1'b0}}};
          flags_d           = '0;
          flags_d[FLG_DZ]   = 1'b1;
        end else begin
          exec_div = 1'b1;
        end
`else
        exec_direct = 1'b1;
        result_d    = '0;
        flags_d     = '1;
`endif
      end
    end

    if (state_q == NORM) begin
      flags_d = '0;
      if (spc_q) begin
        result_d = spc_res_q;
        flags_d  = spc_flg_q;
      end else if (mant_n == '0) begin
        result_d = '0;
      end else if (exp_n >= (1 << EXP_W) - 1) begin
        result_d         = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
        flags_d[FLG_OVF] = 1'b1;
      end else if (exp_n <= 0) begin
        result_d         = {sign_q, {(W-1){1'b0}}};
        flags_d[FLG_UNF] = 1'b1;
      end else begin
        result_d = {sign_q, EXP_W'(exp_n), frac_n};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EXEC;
      EXEC:    state_d = exec_direct ? DONE : (exec_div ? DIV : NORM);
      DIV:     if (div_leave) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign accept = in_valid && in_ready;
  assign result = result_q;
  assign flags  = flags_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;  b_q <= '0;  op_q <= OP_ADD;
      sign_q <= 1'b0;  exp_q <= '0;  mant_q <= '0;
      spc_q <= 1'b0;  spc_res_q <= '0;  spc_flg_q <= '0;
      result_q <= '0;  flags_q <= '0;
    end else begin
      a_q <= a_d;  b_q <= b_d;  op_q <= op_d;
      sign_q <= sign_d;  exp_q <= exp_d;  mant_q <= mant_d;
      spc_q <= spc_d;  spc_res_q <= spc_res_d;  spc_flg_q <= spc_flg_d;
      result_q <= result_d;  flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_alu_seq.sv
// Directed bench for fp_alu_seq at default widths; div expectations follow FPU_DIV_EN.
module tb_fp_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge after the output handshake.
  task automatic run_op(input string tag, input logic [15:0] opa, input logic [15:0] opb,
                        input logic [1:0] opc, input logic [15:0] eres,
                        input logic [2:0] eflg, input int elat);
    int lat;
    a = opa;  b = opb;  op = opc;  in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;  a = 16'hFFFF;  b = 16'hFFFF;  op = 2'b00;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, elat);
    chk({tag, " result"}, result, eres);
    chk({tag, " flags"}, flags, eflg);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " back to idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wait_cnt;
    rst = 1'b0;  in_valid = 1'b0;  out_ready = 1'b0;
    a = '0;  b = '0;  op = '0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    chk("reset flags", flags, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op("add 1+2",        16'h3C00, 16'h4000, 2'b00, 16'h4200, 3'b000, 3);
    run_op("sub cancel",     16'h3C00, 16'h3C00, 2'b01, 16'h0000, 3'b000, 3);
    run_op("sub 1-2",        16'h3C00, 16'h4000, 2'b01, 16'hBC00, 3'b000, 3);
    run_op("add 3+-1",       16'h4200, 16'hBC00, 2'b00, 16'h4000, 3'b000, 3);
    run_op("add 1+1",        16'h3C00, 16'h3C00, 2'b00, 16'h4000, 3'b000, 3);
    run_op("sub 0-2",        16'h0000, 16'h4000, 2'b01, 16'hC000, 3'b000, 3);
    run_op("add inf in",     16'h7C00, 16'h3C00, 2'b00, 16'h7C00, 3'b100, 3);
    run_op("mul 1.5*2",      16'h3E00, 16'h4000, 2'b10, 16'h4200, 3'b000, 3);
    run_op("mul ovf",        16'h7800, 16'h7800, 2'b10, 16'h7C00, 3'b100, 3);
    run_op("mul unf",        16'h0400, 16'h0400, 2'b10, 16'h0000, 3'b010, 3);
    run_op("mul by zero",    16'hC000, 16'h0000, 2'b10, 16'h8000, 3'b000, 3);
`ifdef FPU_DIV_EN
    run_op("div 3/2",        16'h4200, 16'h4000, 2'b11, 16'h3E00, 3'b000, 14);
    run_op("div 2/3",        16'h4000, 16'h4200, 2'b11, 16'h3955, 3'b000, 14);
    run_op("div 0/2",        16'h0000, 16'h4000, 2'b11, 16'h0000, 3'b000, 14);
    run_op("div by zero",    16'h3C00, 16'h0000, 2'b11, 16'h7C00, 3'b001, 2);
`else
    run_op("div disabled",   16'h4200, 16'h4000, 2'b11, 16'h0000, 3'b111, 2);
    run_op("div0 disabled",  16'h3C00, 16'h0000, 2'b11, 16'h0000, 3'b111, 2);
`endif

    // Backpressure: result held in DONE while a competing operand is offered.
    a = 16'h3C00;  b = 16'h3C00;  op = 2'b00;  in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_cnt = 0;
    @(negedge clk);
    while (!out_valid && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("bp reached done", out_valid, 1);
    a = 16'h4000;  b = 16'h4200;  op = 2'b10;  in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp out_valid", out_valid, 1);
      chk("bp in_ready", in_ready, 0);
      chk("bp result", result, 16'h4000);
      chk("bp flags", flags, 0);
    end
    in_valid = 1'b0;  out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp release", {out_valid, in_ready}, 2'b01);
    chk("bp result after release", result, 16'h4000);

    // Reset in the fifth cycle of the divide.
    a = 16'h4200;  b = 16'h4000;  op = 2'b11;  in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(negedge clk);
`ifdef FPU_DIV_EN
    chk("mid-div no valid", out_valid, 0);
`endif
    rst = 1'b0;
    #1;
    chk("abort in_ready", in_ready, 1);
    chk("abort out_valid", out_valid, 0);
    chk("abort result", result, 0);
    chk("abort flags", flags, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("post-reset add", 16'h3C00, 16'h3C00, 2'b00, 16'h4000, 3'b000, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_alu_seq.md
# fp_alu_seq

Parametrised, multi-cycle floating-point arithmetic unit for the FPU datapath. It accepts two packed operands and an opcode over a valid/ready handshake and executes add, subtract, multiply or divide. Results come back through a held valid/ready output with exception flags. It generalises the fixed 16-bit FSM to any exponent/fraction width, adds backpressure and replaces the single-cycle divide with an iterative divider.

## Interface
- EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1
- MAN_W, 10, stored fraction width; hidden 1 implied
- W (derived, not overridable), 1+EXP_W+MAN_W, packed operand/result width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand/opcode presented
- in_ready  out  1  unit can accept; high only in IDLE
- a, b  in  W  operands {sign, biased exp, fraction}
- op  in  2  00 add, 01 sub, 10 mul, 11 div
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes result
- result  out  W  packed result
- flags  out  3  {ovf, unf, dz}

## Operation
- States: IDLE, EXEC, DIV, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register a, b and op; go to EXEC.
  - Inputs changing after acceptance have no effect.
- EXEC, add/sub:
  - For sub, invert b's sign.
  - Align the smaller exponent by right shift; a shift ≥ MAN_W+2 yields 0.
  - Add magnitudes when signs are equal; otherwise subtract the smaller magnitude from the larger, and the sign of the larger wins.
  - Go to NORM.
- EXEC, mul:
  - Sign is the XOR of the operand signs.
  - Exponent = ea+eb-bias, computed at EXP_W+2 bits signed.
  - Mantissa product is (MAN_W+1)x(MAN_W+1).
  - Go to NORM.
- EXEC, div:
  - Divisor exp=0: set dz, result {sign, all-ones, 0}, go to DONE.
  - Otherwise, exponent = ea-eb+bias; go to DIV.
- DIV: restoring divider, one quotient bit per cycle, MAN_W+2 cycles, then NORM.
- NORM:
  - Single-cycle leading-one detect, shifting so the hidden bit is at position MAN_W and adjusting the exponent.
  - Rounding is truncation: discarded bits are dropped.
  - Exponent ≥ all-ones: ovf=1, result {sign, all-ones, 0}.
  - Exponent ≤ 0: unf=1, result {sign, 0, 0}.
  - Go to DONE.
- Zero handling:
  - An operand with exp=0 is zero; its fraction is ignored.
  - Add/sub with one zero operand returns the other operand, sign-adjusted for sub.
  - Exact cancellation returns +0.
  - Mul with any zero operand returns signed zero with no flags.
  - Div of 0 by a nonzero divisor returns signed zero.
- Exp=all-ones on input is treated as overflow and propagates as {sign, all-ones, 0} with ovf=1.
- DONE:
  - out_valid=1; result and flags are held stable until out_ready.
  - On out_valid&out_ready, go to IDLE.
  - No new operand is accepted in the same cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, flags=0, state IDLE.
- Reset mid-operation aborts immediately; no partial result is emitted.
- Latency, counted as accept edge to out_valid rising:
  - add/sub/mul: 3 cycles
  - div: MAN_W+4 cycles (14 at default)
  - div-by-zero: 2 cycles
- Throughput is one operation in flight. in_ready is 0 from the accept edge until the cycle after the DONE handshake.
- out_ready held high in DONE completes the handshake in that cycle.
- result and flags are registered outputs and change only on the NORM→DONE transition, the EXEC→DONE transition or reset.

## Configuration
- FPU_DIV_EN defined: divider and DIV state are present.
- FPU_DIV_EN undefined:
  - op=11 goes EXEC→DONE in 2 cycles with all flags set and result 0.
  - No divider logic is synthesised.

## Structure
- Shared package fp_pkg holds:
  - op encodings OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - state encoding
  - flag bit indices FLG_OVF=2, FLG_UNF=1, FLG_DZ=0
  - bias and hidden-bit helper functions
- Sub-module fp_div_iter: parametrised restoring divider with start/busy/done and a MAN_W+2-bit quotient, instantiated only under FPU_DIV_EN.

## Test plan
- Add, default params: a=0x3C00 (1.0), b=0x4000 (2.0), op=00 → result 0x4200, flags 0, out_valid exactly 3 cycles after accept.
- Sub cancellation: a=b=0x3C00, op=01 → result 0x0000, flags 0; then a=0x3C00, b=0x4000, op=01 → 0xBC00.
- Mul: 0x3E00 x 0x4000 → 0x4200. Overflow case: 0x7800 x 0x7800 → 0x7C00, flags=100.
- Div (FPU_DIV_EN): 0x4200 / 0x4000 → 0x3E00 after 14 cycles. Div by zero: 0x3C00 / 0x0000 → 0x7C00, flags=001 after 2 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result and flags stable, in_ready=0, a second in_valid is ignored. Release → IDLE next cycle.
- Reset mid-DIV: deassert rst at DIV cycle 5 → outputs at reset values immediately; the next operation 0x3C00+0x3C00 → 0x4000 correct.
